// File: rtl/btn_debounce_sync.sv
// btn_debounce_sync: synchronises raw asynchronous button/switch levels and
// debounces them, giving a clean level plus one-cycle rise/fall pulses per channel.
// Latency: CNT_MAX+2 clk edges from the first sampling edge to the btn_db change.
// Backpressure: none. Outputs are valid every cycle.
// Optional macro DEBOUNCE_TOGGLE_EN adds btn_tgl, a per-channel toggle that
// flips on each accepted press.
//
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   btn_in   - raw asynchronous levels, WIDTH channels
//   btn_db   - debounced level per channel
//   btn_rise - one-cycle pulse when btn_db goes 0->1
//   btn_fall - one-cycle pulse when btn_db goes 1->0
//   btn_tgl  - toggle state per channel (DEBOUNCE_TOGGLE_EN only)
module btn_debounce_sync #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_db,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] btn_tgl
`endif
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;

  // Two-flop synchroniser; only s2 is used downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // A channel accepts its new level once it has disagreed with btn_db for
  // CNT_MAX consecutive edges (counter held at CNT_LAST on the last one).
  always_comb begin
    differ = s2 ^ btn_db;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Stable-time counters. Any agreement (bounce back) restarts from zero, and
  // acceptance also returns to zero, so the counter never wraps.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (!differ[i] || accept[i]) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Level and edge pulses are registered together, so each pulse coincides
  // with the btn_db change and lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db   <= '0;
      btn_rise <= '0;
      btn_fall <= '0;
    end else begin
      btn_db   <= btn_db ^ accept;
      btn_rise <= accept & s2;
      btn_fall <= accept & ~s2;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // Flips on the same edge that raises btn_rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_tgl <= '0;
    end else begin
      btn_tgl <= btn_tgl ^ (accept & s2);
    end
  end
`endif

endmodule

// File: tb/tb_btn_debounce_sync.sv
module tb_btn_debounce_sync;

  localparam int W  = 2;
  localparam int CM = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] btn_in;
  logic [W-1:0] btn_db;
  logic [W-1:0] btn_rise;
  logic [W-1:0] btn_fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic [W-1:0] btn_tgl;
`endif

  int total = 0;
  int bad   = 0;

  btn_debounce_sync #(.WIDTH(W), .CNT_MAX(CM)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .btn_tgl  (btn_tgl)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] db,
                           input logic [W-1:0] rise, input logic [W-1:0] fall);
    check({tag, ".db"},   btn_db,   db);
    check({tag, ".rise"}, btn_rise, rise);
    check({tag, ".fall"}, btn_fall, fall);
  endtask

  initial begin
    logic [W-1:0] exp_db;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_tgl;

    // Reset held two cycles with inputs high.
    reset  = 1'b1;
    btn_in = 2'b11;
    step();
    check_all("rst1", 2'b00, 2'b00, 2'b00);
    step();
    check_all("rst2", 2'b00, 2'b00, 2'b00);
`ifdef DEBOUNCE_TOGGLE_EN
    check("rst2.tgl", btn_tgl, 2'b00);
`endif
    reset = 1'b0;
    step();
    check_all("post_rst", 2'b00, 2'b00, 2'b00);

    // Drop inputs before the brief high can be accepted.
    btn_in = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all("settle", 2'b00, 2'b00, 2'b00);
    end

    // Clean press on ch0: accepted after the 6th edge.
    btn_in = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_db = (i == 6) ? 2'b01 : 2'b00;
      check_all("press0", exp_db, exp_db, 2'b00);
    end
    step();
    check_all("press0_after", 2'b01, 2'b00, 2'b00);

    // Clean release on ch0: fall pulse after the 6th edge.
    btn_in = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_all("rel0", (i == 6) ? 2'b00 : 2'b01, 2'b00, (i == 6) ? 2'b01 : 2'b00);
    end
    step();
    check_all("rel0_after", 2'b00, 2'b00, 2'b00);

    // Bounce: 3 high / 3 low, four times, never accepted.
    for (int r = 0; r < 4; r++) begin
      btn_in = 2'b01;
      for (int i = 0; i < 3; i++) begin
        step();
        check_all("bounce_hi", 2'b00, 2'b00, 2'b00);
      end
      btn_in = 2'b00;
      for (int i = 0; i < 3; i++) begin
        step();
        check_all("bounce_lo", 2'b00, 2'b00, 2'b00);
      end
    end
    btn_in = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_db = (i == 6) ? 2'b01 : 2'b00;
      check_all("hold0", exp_db, exp_db, 2'b00);
    end

    // Release ch0 again.
    btn_in = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      step();
    end
    check_all("rel0b", 2'b00, 2'b00, 2'b00);

    // ch0 then ch1 two cycles later: rises two cycles apart.
    btn_in = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 2) btn_in = 2'b11;
      exp_db   = (i >= 8) ? 2'b11 : ((i >= 6) ? 2'b01 : 2'b00);
      exp_rise = (i == 6) ? 2'b01 : ((i == 8) ? 2'b10 : 2'b00);
      check_all("two_ch", exp_db, exp_rise, 2'b00);
    end

    // ch1 starts falling; reset lands while its counter is at 2.
    btn_in = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all("fall1_cnt", 2'b11, 2'b00, 2'b00);
    end
    reset = 1'b1;
    step();
    check_all("mid_rst", 2'b00, 2'b00, 2'b00);
    reset  = 1'b0;
    btn_in = 2'b11;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_db = (i >= 6) ? 2'b11 : 2'b00;
      check_all("after_rst", exp_db, (i == 6) ? 2'b11 : 2'b00, 2'b00);
    end

    // Three clean press/release cycles on ch0 starting from reset.
    reset  = 1'b1;
    btn_in = 2'b00;
    step();
    reset = 1'b0;
    step();
    step();
    check_all("tgl_start", 2'b00, 2'b00, 2'b00);
    for (int p = 0; p < 3; p++) begin
      exp_tgl = {1'b0, (p % 2 == 0)};
      btn_in = 2'b01;
      for (int i = 1; i <= 6; i++) begin
        step();
      end
      check_all("tgl_press", 2'b01, 2'b01, 2'b00);
`ifdef DEBOUNCE_TOGGLE_EN
      check("tgl_press.tgl", btn_tgl, exp_tgl);
`endif
      step();
      check_all("tgl_hold", 2'b01, 2'b00, 2'b00);
      btn_in = 2'b00;
      for (int i = 1; i <= 6; i++) begin
        step();
      end
      check_all("tgl_rel", 2'b00, 2'b00, 2'b01);
`ifdef DEBOUNCE_TOGGLE_EN
      check("tgl_rel.tgl", btn_tgl, exp_tgl);
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
